// File: rtl/hms_sync_ctrl.sv
// rtl/hms_sync_ctrl.sv - synchronous mode/position sequencer and count-enable generator for the hr/min/sec counter bank
//
// Replaces a gated-clock counter scheme: every counter event is a single-cycle
// enable in the clk domain. Owns the 1 Hz prescaler, the debounce sample
// prescaler, per-button sync + debounce, the CLOCK/SETUP mode FSM, the setup
// position select and the setup blink generator.
//
// Ports
//   clk            system clock
//   rst_n          asynchronous active-low reset
//   i_sw0          mode button, active-low, asynchronous
//   i_sw1          position button, active-low, asynchronous
//   i_sw2          increment button, active-low, asynchronous
//   i_sec_at_max   sec counter equals 59
//   i_min_at_max   min counter equals 59
//   o_sec_en       one-cycle increment enable, sec counter
//   o_min_en       one-cycle increment enable, min counter
//   o_hr_en        one-cycle increment enable, hr counter
//   o_mode         0 = CLOCK, 1 = SETUP
//   o_position     00 = SEC, 01 = MIN, 10 = HR
//   o_blink        2 Hz square wave in SETUP, 0 in CLOCK

module hms_sync_ctrl #(
    parameter int CLK_HZ      = 50000000,
    parameter int SAMPLE_DIV  = 500000,
    parameter int DEB_SAMPLES = 3
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       i_sw0,
    input  logic       i_sw1,
    input  logic       i_sw2,
    input  logic       i_sec_at_max,
    input  logic       i_min_at_max,
    output logic       o_sec_en,
    output logic       o_min_en,
    output logic       o_hr_en,
    output logic       o_mode,
    output logic [1:0] o_position,
    output logic       o_blink
);

    localparam int SEC_W      = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
    localparam int SMP_W      = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
    localparam int BLINK_HALF = (CLK_HZ / 4 >= 1) ? (CLK_HZ / 4) : 1;
    localparam int BLK_W      = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;

    localparam logic [SEC_W-1:0] SEC_MAX = SEC_W'(CLK_HZ - 1);
    localparam logic [SMP_W-1:0] SMP_MAX = SMP_W'(SAMPLE_DIV - 1);
    localparam logic [BLK_W-1:0] BLK_MAX = BLK_W'(BLINK_HALF - 1);

    typedef enum logic {
        MODE_CLOCK = 1'b0,
        MODE_SETUP = 1'b1
    } mode_e;

    typedef enum logic [1:0] {
        POS_SEC = 2'b00,
        POS_MIN = 2'b01,
        POS_HR  = 2'b10
    } pos_e;

    // Button index: 0 = mode, 1 = position, 2 = increment.
    localparam int BTN_MODE = 0;
    localparam int BTN_POS  = 1;
    localparam int BTN_INC  = 2;

    logic [2:0] sw_raw;
    assign sw_raw = {i_sw2, i_sw1, i_sw0};

    // ------------------------------------------------------------------
    // Two-flop synchronisers (idle level is 1, buttons are active-low)
    // ------------------------------------------------------------------
    logic [2:0] sync1_q;
    logic [2:0] sync2_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= '1;
            sync2_q <= '1;
        end else begin
            sync1_q <= sw_raw;
            sync2_q <= sync1_q;
        end
    end

    // ------------------------------------------------------------------
    // Debounce sample prescaler
    // ------------------------------------------------------------------
    logic [SMP_W-1:0] smp_cnt_q;
    logic [SMP_W-1:0] smp_cnt_d;
    logic             smp_stb;

    assign smp_stb   = (smp_cnt_q == SMP_MAX);
    assign smp_cnt_d = smp_stb ? '0 : smp_cnt_q + SMP_W'(1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            smp_cnt_q <= '0;
        end else begin
            smp_cnt_q <= smp_cnt_d;
        end
    end

    // ------------------------------------------------------------------
    // Debounce: history shift on each sample strobe; the debounced state
    // (1 = pressed) only changes when the whole history agrees.
    // ------------------------------------------------------------------
    logic [2:0][DEB_SAMPLES-1:0] hist_q;
    logic [2:0][DEB_SAMPLES-1:0] hist_d;
    logic [2:0]                  deb_q;
    logic [2:0]                  deb_d;
    logic [2:0]                  deb_prev_q;
    logic [2:0]                  press;

    always_comb begin
        hist_d = hist_q;
        deb_d  = deb_q;
        for (int b = 0; b < 3; b++) begin
            if (smp_stb) begin
                hist_d[b] = {hist_q[b][DEB_SAMPLES-2:0], sync2_q[b]};
            end
            if (hist_q[b] == '0) begin
                deb_d[b] = 1'b1;
            end else if (hist_q[b] == '1) begin
                deb_d[b] = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hist_q     <= '1;
            deb_q      <= '0;
            deb_prev_q <= '0;
        end else begin
            hist_q     <= hist_d;
            deb_q      <= deb_d;
            deb_prev_q <= deb_q;
        end
    end

    // High for exactly the one cycle after the debounced state goes pressed.
    assign press = deb_q & ~deb_prev_q;

    // ------------------------------------------------------------------
    // Mode / position FSM
    // ------------------------------------------------------------------
    mode_e mode_q;
    mode_e mode_d;
    pos_e  pos_q;
    pos_e  pos_d;

    always_comb begin
        mode_d = mode_q;
        pos_d  = pos_q;
        case (mode_q)
            MODE_CLOCK: begin
                if (press[BTN_MODE]) begin
                    mode_d = MODE_SETUP;
                    pos_d  = POS_SEC;
                end
            end
            MODE_SETUP: begin
                if (press[BTN_POS]) begin
                    case (pos_q)
                        POS_SEC: pos_d = POS_MIN;
                        POS_MIN: pos_d = POS_HR;
                        default: pos_d = POS_SEC;
                    endcase
                end
                if (press[BTN_MODE]) begin
                    mode_d = MODE_CLOCK;
                end
            end
            default: begin
                mode_d = MODE_CLOCK;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mode_q <= MODE_CLOCK;
            pos_q  <= POS_SEC;
        end else begin
            mode_q <= mode_d;
            pos_q  <= pos_d;
        end
    end

    // ------------------------------------------------------------------
    // 1 Hz prescaler. Held at 0 in SETUP so the first tick after leaving
    // SETUP lands a full second later. The tick itself is registered, so
    // it is visible in the cycle after the count hits CLK_HZ-1.
    // ------------------------------------------------------------------
    logic [SEC_W-1:0] sec_cnt_q;
    logic [SEC_W-1:0] sec_cnt_d;
    logic             sec_tick_q;
    logic             sec_tick_d;

    always_comb begin
        sec_cnt_d  = '0;
        sec_tick_d = 1'b0;
        if (mode_q == MODE_CLOCK) begin
            if (sec_cnt_q == SEC_MAX) begin
                sec_tick_d = 1'b1;
            end else begin
                sec_cnt_d = sec_cnt_q + SEC_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sec_cnt_q  <= '0;
            sec_tick_q <= 1'b0;
        end else begin
            sec_cnt_q  <= sec_cnt_d;
            sec_tick_q <= sec_tick_d;
        end
    end

    // ------------------------------------------------------------------
    // Blink generator: half-period CLK_HZ/4 cycles, cleared in CLOCK.
    // ------------------------------------------------------------------
    logic [BLK_W-1:0] blk_cnt_q;
    logic [BLK_W-1:0] blk_cnt_d;
    logic             blink_q;
    logic             blink_d;

    always_comb begin
        blk_cnt_d = '0;
        blink_d   = 1'b0;
        if (mode_q == MODE_SETUP) begin
            blink_d = blink_q;
            if (blk_cnt_q == BLK_MAX) begin
                blink_d = ~blink_q;
            end else begin
                blk_cnt_d = blk_cnt_q + BLK_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            blk_cnt_q <= '0;
            blink_q   <= 1'b0;
        end else begin
            blk_cnt_q <= blk_cnt_d;
            blink_q   <= blink_d;
        end
    end

    // ------------------------------------------------------------------
    // Count enables. Everything here is decoded from registered state, so
    // every output is 0 while reset is asserted and in the release cycle.
    // All button pulses share one sample phase, so a CLOCK tick and a SETUP
    // increment can never land in adjacent cycles.
    // ------------------------------------------------------------------
    always_comb begin
        o_sec_en = 1'b0;
        o_min_en = 1'b0;
        o_hr_en  = 1'b0;
        if (mode_q == MODE_CLOCK) begin
            o_sec_en = sec_tick_q;
            o_min_en = sec_tick_q & i_sec_at_max;
            o_hr_en  = sec_tick_q & i_sec_at_max & i_min_at_max;
        end else if (press[BTN_INC]) begin
            case (pos_q)
                POS_SEC: o_sec_en = 1'b1;
                POS_MIN: o_min_en = 1'b1;
                POS_HR:  o_hr_en  = 1'b1;
                default: o_sec_en = 1'b0;
            endcase
        end
    end

    assign o_mode     = mode_q;
    assign o_position = pos_q;
    assign o_blink    = blink_q & (mode_q == MODE_SETUP);

endmodule

// File: doc/hms_sync_ctrl.md
Name: hms_sync_ctrl

Overview:
- Fully synchronous sequencer for the hour/minute/second counter datapath. It replaces the gated-clock scheme, where counters are clocked by switch or max-hit signals, with single-cycle count enables in the clk domain.
- Owns the 1 Hz prescaler, button synchronisation and debounce, the CLOCK/SETUP mode FSM and setup position select. It also generates the ripple-carry enables for the sec/min/hr counters.
- Sits between the top-level switches and the hrminsec counter bank. Its mode, position and blink outputs also feed the display mux.

Parameters:
- CLK_HZ, 50000000, clk cycles per 1 Hz tick.
- SAMPLE_DIV, 500000, clk cycles per debounce sample tick (100 Hz at 50 MHz).
- DEB_SAMPLES, 3, consecutive equal samples required to change debounced button state (2..8).

Ports:
- clk  input  1  system clock
- rst_n  input  1  asynchronous active-low reset
- i_sw0  input  1  mode button, active-low, asynchronous
- i_sw1  input  1  position button, active-low, asynchronous
- i_sw2  input  1  increment button, active-low, asynchronous
- i_sec_at_max  input  1  sec counter currently equals its max (59)
- i_min_at_max  input  1  min counter currently equals its max (59)
- o_sec_en  output  1  one-cycle increment enable, sec counter
- o_min_en  output  1  one-cycle increment enable, min counter
- o_hr_en  output  1  one-cycle increment enable, hr counter
- o_mode  output  1  0 = CLOCK, 1 = SETUP
- o_position  output  2  00 = SEC, 01 = MIN, 10 = HR; 11 never driven
- o_blink  output  1  2 Hz square wave in SETUP, 0 in CLOCK

Behaviour:
- Reset:
  - All outputs 0; mode CLOCK, position SEC.
  - Prescalers 0, debounced states "released", sync flops 1.
  - Reset is asynchronous and may assert at any cycle. No enable pulse may be emitted in the cycle reset deasserts.
- Input sync: each i_swN passes through 2 flops before use.
- Sample tick:
  - Free-running counter 0..SAMPLE_DIV-1.
  - One-cycle sample strobe when the count equals SAMPLE_DIV-1, then wraps to 0.
- Debounce, per button:
  - On each sample strobe, shift the synchronised level into a DEB_SAMPLES-bit history.
  - Debounced state becomes "pressed" when the history is all 0, and "released" when it is all 1. Otherwise it holds.
  - A press pulse (1 cycle) fires in the cycle after the state goes released->pressed.
  - Release produces no pulse. A held button produces exactly one pulse.
- Second tick:
  - Counter 0..CLK_HZ-1, counting in CLOCK mode only.
  - sec_tick (1 cycle) when the count equals CLK_HZ-1.
  - In SETUP the counter is held at 0, so the first tick after returning to CLOCK occurs CLK_HZ cycles later.
- Mode FSM:
  - CLOCK --sw0 pulse--> SETUP, with position forced to SEC on entry.
  - SETUP --sw0 pulse--> CLOCK. The new mode is visible the cycle after the pulse.
- Position:
  - Advances on an sw1 pulse, only in SETUP: SEC->MIN->HR->SEC.
  - Ignored in CLOCK; value is held in CLOCK.
- Enables in CLOCK, combinational from registered state and registered ticks:
  - o_sec_en = sec_tick.
  - o_min_en = sec_tick & i_sec_at_max.
  - o_hr_en = sec_tick & i_sec_at_max & i_min_at_max.
- Enables in SETUP:
  - An sw2 pulse asserts only the enable for the current position, for exactly 1 cycle.
  - No carry is propagated; i_*_at_max are ignored.
- Ignored inputs: sw2 pulse in CLOCK; sw1 pulse in CLOCK.
- Simultaneous events:
  - sw0 pulse coincident with sec_tick in CLOCK: the tick's enables are issued, then mode changes.
  - sw0 and sw2 pulses coincident in SETUP: the sw2 increment is applied to the current position, then mode changes.
  - sw1 and sw2 pulses coincident in SETUP: the increment goes to the old position, then position advances.
- Enable outputs are never high for 2 consecutive cycles.
- o_blink: toggles every CLK_HZ/4 cycles while in SETUP; forced 0 and its counter cleared in CLOCK.
- Hr wrap and the hr max are the counter's responsibility. The controller never inspects hr.

Test Plan (CLK_HZ=40, SAMPLE_DIV=2, DEB_SAMPLES=3):
- Reset, CLOCK, inputs idle, at_max=0 -> o_sec_en pulses at cycles 40, 80, 120 after reset release; o_min_en and o_hr_en stay 0.
- CLOCK, i_sec_at_max=1, i_min_at_max=1 at a tick -> sec/min/hr enables all high for that single cycle; with i_min_at_max=0 only sec and min fire.
- sw0 held low 20 cycles -> one press pulse; o_mode 0->1, o_position=00, o_blink toggles every 10 cycles, o_sec_en silent for 200 cycles.
- SETUP: sw1 pressed 3 times -> o_position 01, 10, 00. At position 10 an sw2 press -> o_hr_en alone for 1 cycle, even with both at_max=1.
- sw2 glitch (low 3 cycles, i.e. fewer than 3 samples) -> no pulse. sw2 press in CLOCK -> no enable. Second sw0 press -> o_mode=0 and next o_sec_en exactly 40 cycles later.
- Assert rst_n mid-SETUP with sw2 held low -> all outputs 0 immediately. After release, no pulse until sw2 is released and pressed again.
